uop_pair_queue: RTL and testbench

// - Receiving end of the uop_fetch instruction-pair interface. Accepts up to two

---
 rtl/uop_pair_queue_pkg.sv | 14 +
 rtl/uop_queue_mem.sv | 35 +++
 rtl/uop_pair_queue.sv | 84 ++++++++
 tb/tb_uop_pair_queue.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uop_pair_queue_pkg.sv
// Shared types and defaults for the fetch-to-decode instruction pair queue.
// Each queue entry carries one instruction word and its branch tag.
package uop_pair_queue_pkg;

  localparam int MAX_PREDICT_DEPTH_BITS = 4;
  localparam int UOP_QUEUE_DEPTH        = 8;
  localparam int INSTR_W                = 32;

  typedef struct packed {
    logic [INSTR_W-1:0]                instr;
    logic [MAX_PREDICT_DEPTH_BITS-1:0] tag;
  } uop_entry_t;

endpackage

// File: rtl/uop_queue_mem.sv
// Entry storage for the pair queue: two write ports at consecutive (wrapping)
// addresses driven by one enable, plus one combinational read port.
module uop_queue_mem #(
  parameter  int DEPTH = 8,
  parameter  int W     = 36,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata_a,
  input  logic [W-1:0]  wdata_b,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] waddr_b;

  // Power-of-two depth lets the second slot wrap by natural overflow.
  assign waddr_b = waddr + AW'(1);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (we && (waddr == AW'(gi))) begin
        mem_q[gi] <= wdata_a;
      end else if (we && (waddr_b == AW'(gi))) begin
        mem_q[gi] <= wdata_b;
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uop_pair_queue.sv
// Accepts up to two instructions per cycle from fetch and drains one per cycle to
// decode; the stall back to fetch depends only on the registered occupancy.
module uop_pair_queue
  import uop_pair_queue_pkg::*;
#(
  parameter int DEPTH    = UOP_QUEUE_DEPTH,
  parameter int TAG_BITS = MAX_PREDICT_DEPTH_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                prev_valid,
  input  logic [31:0]         instruction_1,
  input  logic [31:0]         instruction_2,
  input  logic [TAG_BITS-1:0] branch_tag_1,
  input  logic [TAG_BITS-1:0] branch_tag_2,
  output logic                stalled,
  output logic                valid,
  output logic [31:0]         instruction,
  output logic [TAG_BITS-1:0] branch_tag,
  input  logic                next_stalled
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = 32 + TAG_BITS;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [W-1:0]  head;

  // Fewer than two free slots blocks a whole pair; a same-cycle pop does not help.
  assign stalled = (count_q >= CW'(DEPTH - 1));
  assign valid   = (count_q != '0);
  assign push    = prev_valid && !stalled && !clear;
  assign pop     = valid && !next_stalled && !clear;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(2);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'({push, 1'b0}) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  uop_queue_mem #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .waddr   (wr_ptr_q),
    .wdata_a ({instruction_1, branch_tag_1}),
    .wdata_b ({instruction_2, branch_tag_2}),
    .raddr   (rd_ptr_q),
    .rdata   (head)
  );

  // Head is forced to zero when empty so decode never sees stale storage.
  assign instruction = valid ? head[W-1:TAG_BITS] : '0;
  assign branch_tag  = valid ? head[TAG_BITS-1:0] : '0;

endmodule

// File: tb/tb_uop_pair_queue.sv
// Bench for uop_pair_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the FIFO rules.
module tb_uop_pair_queue;
  import uop_pair_queue_pkg::*;

  localparam int DEPTH = UOP_QUEUE_DEPTH;
  localparam int TB    = MAX_PREDICT_DEPTH_BITS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          prev_valid = 1'b0;
  logic [31:0]   instruction_1 = '0, instruction_2 = '0;
  logic [TB-1:0] branch_tag_1 = '0, branch_tag_2 = '0;
  logic          stalled, valid;
  logic [31:0]   instruction;
  logic [TB-1:0] branch_tag;
  logic          next_stalled = 1'b0;

  int checks = 0;
  int errors = 0;

  uop_entry_t mq[$];

  always #5 clk = ~clk;

  uop_pair_queue dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .prev_valid    (prev_valid),
    .instruction_1 (instruction_1),
    .instruction_2 (instruction_2),
    .branch_tag_1  (branch_tag_1),
    .branch_tag_2  (branch_tag_2),
    .stalled       (stalled),
    .valid         (valid),
    .instruction   (instruction),
    .branch_tag    (branch_tag),
    .next_stalled  (next_stalled)
  );

  // Model expectation packed as {stalled, valid, instruction, tag}.
  function automatic logic [33+TB:0] model_out();
    logic s, v;
    s = (DEPTH - mq.size()) < 2;
    v = mq.size() != 0;
    if (v) return {s, v, mq[0].instr, mq[0].tag};
    return {s, v, 32'h0, {TB{1'b0}}};
  endfunction

  // Advance one clock; the model applies the FIFO rules to the inputs in force.
  task automatic step(output bit accepted);
    bit push, pop;
    uop_entry_t e1, e2;
    push = prev_valid && ((DEPTH - mq.size()) >= 2) && !clear;
    pop  = (mq.size() != 0) && !next_stalled && !clear;
    e1.instr = instruction_1; e1.tag = branch_tag_1;
    e2.instr = instruction_2; e2.tag = branch_tag_2;
    @(posedge clk);
    if (clear) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(e1);
        mq.push_back(e2);
      end
    end
    #1;
    accepted = push;
  endtask

  task automatic drive_pair(input logic [31:0] a, input logic [31:0] b,
                            input logic [TB-1:0] ta, input logic [TB-1:0] tb_);
    prev_valid = 1'b1;
    instruction_1 = a; instruction_2 = b;
    branch_tag_1 = ta; branch_tag_2 = tb_;
  endtask

  task automatic do_reset();
    prev_valid = 1'b0; clear = 1'b0; next_stalled = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete();
  endtask

  task automatic test_reset();
    bit acc;
    logic [33+TB:0] obs;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(acc);
      obs = {stalled, valid, instruction, branch_tag};
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_idle: got %h expected 0", obs);
      end
    end
    // Build count = 5, then hit reset mid-cycle.
    next_stalled = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_pair(32'h100 + k, 32'h200 + k, TB'(k), TB'(k + 1));
      step(acc);
    end
    prev_valid = 1'b0; next_stalled = 1'b0;
    step(acc);
    obs = {stalled, valid, instruction, branch_tag};
    checks++;
    if (obs !== model_out() || mq.size() != 5) begin
      errors++;
      $display("FAIL reset_prefill: got %h expected %h", obs, model_out());
    end
    next_stalled = 1'b1;
    #2 reset = 1'b1;
    #1;
    obs = {stalled, valid, instruction, branch_tag};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_async: got %h expected 0", obs);
    end
    mq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    next_stalled = 1'b0;
  endtask

  task automatic test_single_pair();
    bit acc;
    logic [33+TB:0] obs;
    logic [33+TB:0] exp_seq [3];
    exp_seq[0] = {1'b0, 1'b1, 32'h11, TB'(1)};
    exp_seq[1] = {1'b0, 1'b1, 32'h22, TB'(2)};
    exp_seq[2] = '0;
    drive_pair(32'h11, 32'h22, TB'(1), TB'(2));
    next_stalled = 1'b0;
    step(acc);
    prev_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      obs = {stalled, valid, instruction, branch_tag};
      checks++;
      if (obs !== exp_seq[i]) begin
        errors++;
        $display("FAIL single_pair cycle %0d: got %h expected %h", i + 1, obs, exp_seq[i]);
      end
      step(acc);
    end
  endtask

  task automatic test_fill();
    bit acc;
    logic [33+TB:0] obs;
    logic [31:0] got[$];
    int k;
    next_stalled = 1'b1;
    for (int p = 0; p < 4; p++) begin
      drive_pair(32'(2 * p + 1), 32'(2 * p + 2), TB'(p), TB'(p + 8));
      step(acc);
    end
    obs = {stalled, valid, instruction, branch_tag};
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h01, TB'(0)}) begin
      errors++;
      $display("FAIL fill_full: got %h expected %h", obs, {1'b1, 1'b1, 32'h01, TB'(0)});
    end
    drive_pair(32'h09, 32'h0A, TB'(5), TB'(6));
    for (int i = 0; i < 3; i++) begin
      step(acc);
      checks++;
      if (stalled !== 1'b1 || valid !== 1'b1 || instruction !== 32'h01) begin
        errors++;
        $display("FAIL fill_hold %0d: got stalled=%b instr=%h expected stalled=1 instr=01", i, stalled, instruction);
      end
    end
    next_stalled = 1'b0;
    k = 0;
    while (valid && k < 40) begin
      obs = {stalled, valid, instruction, branch_tag};
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL fill_drain: got %h expected %h", obs, model_out());
      end
      got.push_back(instruction);
      step(acc);
      if (acc) prev_valid = 1'b0;
      k++;
    end
    checks++;
    if (got.size() != 10) begin
      errors++;
      $display("FAIL fill_count: got %0d entries expected 10", got.size());
    end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      checks++;
      if (got[i] !== 32'(i + 1)) begin
        errors++;
        $display("FAIL fill_order %0d: got %h expected %h", i, got[i], 32'(i + 1));
      end
    end
  endtask

  task automatic test_push_pop_boundary();
    bit acc;
    // {count before, push accepted?, stalled after}
    bit exp_acc [3];
    bit exp_stall [3];
    exp_acc[0] = 1'b1; exp_stall[0] = 1'b0;   // 5 -> 6
    exp_acc[1] = 1'b1; exp_stall[1] = 1'b1;   // 6 -> 7
    exp_acc[2] = 1'b0; exp_stall[2] = 1'b0;   // 7 -> 6, pair refused
    next_stalled = 1'b1;
    for (int p = 0; p < 3; p++) begin
      drive_pair(32'h300 + p, 32'h400 + p, TB'(p), TB'(p));
      step(acc);
    end
    prev_valid = 1'b0; next_stalled = 1'b0;
    step(acc);
    for (int i = 0; i < 3; i++) begin
      drive_pair(32'h500 + i, 32'h600 + i, TB'(i), TB'(i));
      step(acc);
      checks++;
      if (acc !== exp_acc[i] || stalled !== exp_stall[i] || valid !== 1'b1 ||
          instruction !== model_out()[31+TB:TB]) begin
        errors++;
        $display("FAIL pushpop %0d: got stalled=%b instr=%h expected stalled=%b instr=%h accept=%b",
                 i, stalled, instruction, exp_stall[i], model_out()[31+TB:TB], exp_acc[i]);
      end
    end
    prev_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(acc);
      checks++;
      if ({stalled, valid, instruction, branch_tag} !== model_out()) begin
        errors++;
        $display("FAIL pushpop_drain %0d: got %h expected %h", i,
                 {stalled, valid, instruction, branch_tag}, model_out());
      end
    end
  endtask

  task automatic test_wrap();
    bit acc;
    logic [31:0] exp_order [4];
    exp_order[0] = 32'hA0; exp_order[1] = 32'hA1;
    exp_order[2] = 32'hB0; exp_order[3] = 32'hB1;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      drive_pair(32'h700 + p, 32'h800 + p, TB'(p), TB'(p));
      step(acc);
      prev_valid = 1'b0;
      step(acc);
      step(acc);
    end
    next_stalled = 1'b1;
    drive_pair(32'hA0, 32'hA1, TB'(3), TB'(4));
    step(acc);
    drive_pair(32'hB0, 32'hB1, TB'(5), TB'(6));
    step(acc);
    prev_valid = 1'b0; next_stalled = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid !== 1'b1 || instruction !== exp_order[i]) begin
        errors++;
        $display("FAIL wrap %0d: got valid=%b instr=%h expected valid=1 instr=%h",
                 i, valid, instruction, exp_order[i]);
      end
      step(acc);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_empty: got valid=%b expected 0", valid);
    end
  endtask

  task automatic test_clear();
    bit acc;
    logic [33+TB:0] obs;
    next_stalled = 1'b1;
    for (int p = 0; p < 2; p++) begin
      drive_pair(32'h900 + p, 32'h910 + p, TB'(p), TB'(p));
      step(acc);
    end
    drive_pair(32'hCC, 32'hDD, TB'(7), TB'(7));
    next_stalled = 1'b0;
    clear = 1'b1;
    step(acc);
    clear = 1'b0; prev_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      obs = {stalled, valid, instruction, branch_tag};
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL clear %0d: got %h expected 0", i, obs);
      end
      step(acc);
    end
  endtask

  task automatic test_random();
    bit acc;
    logic [33+TB:0] obs;
    for (int i = 0; i < 400; i++) begin
      if (!prev_valid || acc)
        drive_pair($urandom, $urandom, TB'($urandom), TB'($urandom));
      prev_valid   = ($urandom_range(0, 3) != 0);
      next_stalled = ($urandom_range(0, 2) == 0);
      clear        = ($urandom_range(0, 29) == 0);
      step(acc);
      obs = {stalled, valid, instruction, branch_tag};
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL random %0d: got %h expected %h", i, obs, model_out());
      end
    end
    clear = 1'b0; prev_valid = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_single_pair();
    test_fill();
    test_push_pop_boundary();
    test_wrap();
    test_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
